mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding HI/LO, one radix-2 step per cycle.
// Latency 32 cycles after accept (divide-by-zero finishes after 1); start is ignored unless idle.
module mult_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic [31:0] wr_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] opd_q, opd_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dbz_q, dbz_d;

   logic        sgn_op, rs_neg, rt_neg;
   logic [31:0] rs_mag, rt_mag;
   logic [32:0] add_sum, sub_diff;
   logic [63:0] acc_step, prod_fix;
   logic [31:0] quo_fix, rem_fix;

   // Multiply: acc = {partial sum, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
   always_comb begin
      add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
      sub_diff = {acc_q[63:32], acc_q[31]} - {1'b0, opd_q};
      if (is_div_q) begin
         if (!sub_diff[32])
            acc_step = {sub_diff[31:0], acc_q[30:0], 1'b1};
         else
            acc_step = {acc_q[62:0], 1'b0};
      end else begin
         acc_step = {add_sum, acc_q[31:1]};
      end
      prod_fix = neg_res_q ? -acc_step : acc_step;
      quo_fix  = neg_res_q ? -acc_step[31:0] : acc_step[31:0];
      rem_fix  = neg_rem_q ? -acc_step[63:32] : acc_step[63:32];
   end

   always_comb begin
      sgn_op = ~op[0];
      rs_neg = sgn_op & rs_data[31];
      rt_neg = sgn_op & rt_data[31];
      rs_mag = rs_neg ? -rs_data : rs_data;
      rt_mag = rt_neg ? -rt_data : rt_data;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      opd_d     = opd_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d     = 6'd0;
               busy_d    = 1'b1;
               is_div_d  = op[1];
               neg_res_d = rs_neg ^ rt_neg;
               neg_rem_d = rs_neg;
               if (op[1]) begin
                  opd_d = rt_mag;
                  acc_d = {32'd0, rs_mag};
               end else begin
                  opd_d = rs_mag;
                  acc_d = {32'd0, rt_mag};
               end
               state_d = (op[1] && (rt_data == 32'd0)) ? S_FIN : S_CALC;
            end else begin
               if (wr_hi) hi_d = wr_data;
               if (wr_lo) lo_d = wr_data;
            end
         end
         S_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[63:32];
                  lo_d = prod_fix[31:0];
               end
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            // busy still set here only on the divide-by-zero shortcut
            if (busy_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               dbz_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opd_q     <= 32'd0;
         acc_q     <= 64'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         opd_q     <= opd_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed literal cases plus randomized traffic against an arithmetic model.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] rs_data = 32'd0;
   logic [31:0] rt_data = 32'd0;
   logic        wr_hi = 1'b0;
   logic        wr_lo = 1'b0;
   logic [31:0] wr_data = 32'd0;
   logic [31:0] hi, lo;
   logic        busy, done, div_by_zero;

   mult_div_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference {hi, lo} from plain arithmetic; never called for a zero divisor.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      int     qa, qb;
      case (o)
         2'd0: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
         end
         2'd1: return {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return {32'd0, 32'h8000_0000};
            qa = $signed(a);
            qb = $signed(b);
            return {32'(qa % qb), 32'(qa / qb)};
         end
         default: return {a % b, a / b};
      endcase
   endfunction

   // Model: mk = edges since accept, -1 when idle.
   int          mk = -1;
   bit          m_dz = 1'b0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic [63:0] m_pend = 64'd0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mk   <= -1;
         m_dz <= 1'b0;
         m_hi <= 32'd0;
         m_lo <= 32'd0;
      end else if (mk < 0) begin
         if (start) begin
            mk   <= 0;
            m_dz <= op[1] && (rt_data == 32'd0);
            if (!(op[1] && (rt_data == 32'd0)))
               m_pend <= ref_result(op, rs_data, rt_data);
         end else begin
            if (wr_hi) m_hi <= wr_data;
            if (wr_lo) m_lo <= wr_data;
         end
      end else begin
         mk <= (mk == (m_dz ? 1 : 32)) ? -1 : mk + 1;
         if (!m_dz && mk == 31) begin
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      chk("busy", busy, (mk >= 0) && (m_dz ? (mk == 0) : (mk < 32)));
      chk("done", done, m_dz ? (mk == 1) : (mk == 32));
      chk("div_by_zero", div_by_zero, m_dz && (mk == 1));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(negedge clk);
      start = 1'b0; rs_data = $urandom; rt_data = $urandom;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      issue(o, a, b);
      repeat (34) @(negedge clk);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom % 16);
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int bc, dc;
      #1 rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_hi", hi, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;

      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      bc = 0; dc = 0;
      repeat (40) begin
         bc += int'(busy);
         dc += int'(done);
         @(negedge clk);
      end
      chk("multu_busy_cycles", bc, 32);
      chk("multu_done_cycles", dc, 1);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);

      run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFF1);
      run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      run_op(2'd3, 32'd100, 32'd7);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_lo", lo, 32'h8000_0000);
      chk("div_ovf_hi", hi, 32'h0000_0000);

      @(negedge clk); wr_hi = 1'b1; wr_data = 32'h1234_5678;
      @(negedge clk); wr_hi = 1'b0;
      chk("mthi_idle", hi, 32'h1234_5678);
      issue(2'd1, 32'd7, 32'd9);
      wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
      @(negedge clk); wr_hi = 1'b0;
      chk("mthi_busy", hi, 32'h1234_5678);
      repeat (34) @(negedge clk);
      chk("multu_small_lo", lo, 32'd63);

      @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
      @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0;
      chk("mt_both_hi", hi, 32'hCAFE_F00D);
      chk("mt_both_lo", lo, 32'hCAFE_F00D);

      @(negedge clk); wr_hi = 1'b1; wr_data = 32'hAAAA_0000;
      @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h0000_5555;
      @(negedge clk); wr_lo = 1'b0;
      issue(2'd3, 32'h0000_0064, 32'd0);
      chk("dz_busy", busy, 1);
      chk("dz_done_early", done, 0);
      @(negedge clk);
      chk("dz_done", done, 1);
      chk("dz_flag", div_by_zero, 1);
      @(negedge clk);
      chk("dz_done_clear", done, 0);
      chk("dz_hi", hi, 32'hAAAA_0000);
      chk("dz_lo", lo, 32'h0000_5555);

      @(negedge clk);
      start = 1'b1; op = 2'd1; rs_data = 32'd2; rt_data = 32'd3;
      wr_hi = 1'b1; wr_data = 32'h1111_1111;
      @(negedge clk); start = 1'b0; wr_hi = 1'b0;
      chk("start_wins_busy", busy, 1);
      repeat (34) @(negedge clk);
      chk("start_wins_hi", hi, 32'd0);
      chk("start_wins_lo", lo, 32'd6);

      issue(2'd0, 32'h0000_1234, 32'h0000_5678);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 2'd1; rs_data = 32'd5; rt_data = 32'd5;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      @(negedge clk);
      rst = 1'b0; start = 1'b1; op = 2'd3; rs_data = 32'd100; rt_data = 32'd7;
      @(negedge clk); start = 1'b0;
      chk("post_rst_accept", busy, 1);
      repeat (34) @(negedge clk);
      chk("post_rst_lo", lo, 32'd14);
      chk("post_rst_hi", hi, 32'd2);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst     = ($urandom % 700) == 0;
         start   = ($urandom % 8) == 0;
         op      = 2'($urandom);
         rs_data = pick();
         rt_data = pick();
         wr_hi   = ($urandom % 6) == 0;
         wr_lo   = ($urandom % 6) == 0;
         wr_data = $urandom;
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
